jt12_timer_bank: RTL and testbench

Parametrised bank of NT independent down-stream timers for the FM core, superseding the fixed A/B timer pair. Each channel has its own prescaler divisor, one-shot or auto-reload mode, sticky flag and IRQ enable. All channels advance on the shared sample tick (cen & zero). The bank sits beside the register interface and feeds the status byte, the CSM key-on logic (overflow) and the CPU interrupt line.

---
 rtl/jt12_timer_bank_pkg.sv | 23 ++
 rtl/jt12_timer_ch.sv | 106 ++++++++++
 rtl/jt12_timer_bank.sv | 59 +++++
 tb/tb_jt12_timer_bank.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jt12_timer_bank_pkg.sv
// Shared definitions for the jt12 timer bank.
//   - default geometry (channel count, counter width, prescaler width)
//   - channel mode encoding (auto-reload / one-shot)
//   - per-clock channel action, decoded from run / run edge / tick
package jt12_timer_bank_pkg;

  localparam int unsigned NT_DEF = 2;
  localparam int unsigned CW_DEF = 10;
  localparam int unsigned PW_DEF = 4;

  typedef enum logic {
    MODE_RELOAD  = 1'b0,
    MODE_ONESHOT = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    ACT_IDLE  = 2'd0,
    ACT_STOP  = 2'd1,
    ACT_START = 2'd2,
    ACT_TICK  = 2'd3
  } ch_act_e;

endpackage

// File: rtl/jt12_timer_ch.sv
// One timer channel: prescaler, up-counter, active bit, sticky flag and a
// registered one-clk overflow pulse.
// Ports:
//   clk, rst_n      core clock, async active-low reset
//   tick            shared sample tick (cen & zero)
//   start_value     reload value
//   presc           prescaler terminal count (divide by presc+1)
//   run             enable; a rising edge (re)starts the channel
//   oneshot         1 = stop after first overflow
//   clr_flag        synchronous flag clear, not gated by tick
//   flag            sticky overflow flag
//   overflow        one-clk overflow pulse
module jt12_timer_ch
  import jt12_timer_bank_pkg::*;
#(
  parameter int unsigned CW = CW_DEF,
  parameter int unsigned PW = PW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick,
  input  logic [CW-1:0] start_value,
  input  logic [PW-1:0] presc,
  input  logic          run,
  input  logic          oneshot,
  input  logic          clr_flag,
  output logic          flag,
  output logic          overflow
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          active_q, active_d;
  logic          run_l_q;
  logic          flag_q, flag_d;
  logic          ovf_q, ovf_d;
  ch_act_e       act;
  mode_e         mode;

  assign mode = mode_e'(oneshot);

  // Start outranks a coincident tick, so a run edge never also counts.
  always_comb begin
    if (!run)                  act = ACT_STOP;
    else if (!run_l_q)         act = ACT_START;
    else if (tick && active_q) act = ACT_TICK;
    else                       act = ACT_IDLE;
  end

  always_comb begin
    cnt_d    = cnt_q;
    pcnt_d   = pcnt_q;
    active_d = active_q;
    ovf_d    = 1'b0;
    case (act)
      ACT_STOP: active_d = 1'b0;
      ACT_START: begin
        cnt_d    = start_value;
        pcnt_d   = '0;
        active_d = 1'b1;
      end
      ACT_TICK: begin
        if (pcnt_q == presc) begin
          pcnt_d = '0;
          if (cnt_q == '1) begin
            cnt_d = start_value;
            ovf_d = 1'b1;
            if (mode == MODE_ONESHOT) active_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
      ACT_IDLE: ;
      default: ;
    endcase
    // Clear beats a same-cycle wrap; the pulse itself is unaffected.
    if (clr_flag)   flag_d = 1'b0;
    else if (ovf_d) flag_d = 1'b1;
    else            flag_d = flag_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      pcnt_q   <= '0;
      active_q <= 1'b0;
      run_l_q  <= 1'b0;
      flag_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      pcnt_q   <= pcnt_d;
      active_q <= active_d;
      run_l_q  <= run;
      flag_q   <= flag_d;
      ovf_q    <= ovf_d;
    end
  end

  assign flag     = flag_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/jt12_timer_bank.sv
// Bank of NT independent timers advancing on the shared sample tick.
// Ports:
//   clk, rst_n      core clock, async active-low reset
//   cen, zero       clock enable and sample strobe; tick = cen & zero
//   start_value     NT*CW reload values, channel i at [i*CW +: CW]
//   presc           NT*PW prescaler terminal counts
//   run, oneshot    per-channel enable (edge starts) and one-shot mode
//   clr_flag        per-channel synchronous flag clear
//   irq_en          per-channel interrupt enable
//   flag, overflow  sticky flags and one-clk overflow pulses
//   irq_n           active-low interrupt, ~|(flag & irq_en)
module jt12_timer_bank
  import jt12_timer_bank_pkg::*;
#(
  parameter int unsigned NT = NT_DEF,
  parameter int unsigned CW = CW_DEF,
  parameter int unsigned PW = PW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cen,
  input  logic            zero,
  input  logic [NT*CW-1:0] start_value,
  input  logic [NT*PW-1:0] presc,
  input  logic [NT-1:0]   run,
  input  logic [NT-1:0]   oneshot,
  input  logic [NT-1:0]   clr_flag,
  input  logic [NT-1:0]   irq_en,
  output logic [NT-1:0]   flag,
  output logic [NT-1:0]   overflow,
  output logic            irq_n
);

  logic tick;

  assign tick = cen & zero;

  for (genvar i = 0; i < NT; i++) begin : g_ch
    jt12_timer_ch #(
      .CW (CW),
      .PW (PW)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .tick        (tick),
      .start_value (start_value[i*CW +: CW]),
      .presc       (presc[i*PW +: PW]),
      .run         (run[i]),
      .oneshot     (oneshot[i]),
      .clr_flag    (clr_flag[i]),
      .flag        (flag[i]),
      .overflow    (overflow[i])
    );
  end

  // Combinational from registered flags so irq_en masks without a clock.
  assign irq_n = ~|(flag & irq_en);

endmodule

// File: tb/tb_jt12_timer_bank.sv
// Bench for jt12_timer_bank: a directed vector table, hand sequences for the
// multi-cycle corners, and a randomized run against a ticks-remaining model.
module tb_jt12_timer_bank;

  localparam int NT = 2;
  localparam int CW = 10;
  localparam int PW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cen, zero;
  logic [NT*CW-1:0] start_value;
  logic [NT*PW-1:0] presc;
  logic [NT-1:0]   run, oneshot, clr_flag, irq_en;
  logic [NT-1:0]   flag, overflow;
  logic            irq_n;

  int total = 0;
  int bad   = 0;

  // Model: each channel tracks ticks remaining until its next overflow.
  int m_rem [NT];
  bit m_act [NT];
  bit m_rl  [NT];
  bit m_flag[NT];
  bit m_ovf [NT];

  typedef struct {
    logic run0, cen, zero, clr0;
    logic ovf0, flag0, irqn;
  } vec_t;
  vec_t tbl[18];

  always #5 clk = ~clk;

  jt12_timer_bank #(
    .NT (NT),
    .CW (CW),
    .PW (PW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cen         (cen),
    .zero        (zero),
    .start_value (start_value),
    .presc       (presc),
    .run         (run),
    .oneshot     (oneshot),
    .clr_flag    (clr_flag),
    .irq_en      (irq_en),
    .flag        (flag),
    .overflow    (overflow),
    .irq_n       (irq_n)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic int period(input int i);
    return (int'(presc[i*PW +: PW]) + 1) * ((1 << CW) - int'(start_value[i*CW +: CW]));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NT; i++) begin
      m_rem[i] = 0; m_act[i] = 0; m_rl[i] = 0; m_flag[i] = 0; m_ovf[i] = 0;
    end
  endtask

  task automatic model_step();
    bit tk;
    tk = cen & zero;
    for (int i = 0; i < NT; i++) begin
      m_ovf[i] = 0;
      if (!run[i]) begin
        m_act[i] = 0;
      end else if (!m_rl[i]) begin
        m_act[i] = 1;
        m_rem[i] = period(i);
      end else if (tk && m_act[i]) begin
        m_rem[i]--;
        if (m_rem[i] == 0) begin
          m_ovf[i] = 1;
          m_rem[i] = period(i);
          if (oneshot[i]) m_act[i] = 0;
        end
      end
      if (clr_flag[i])   m_flag[i] = 0;
      else if (m_ovf[i]) m_flag[i] = 1;
      m_rl[i] = run[i];
    end
  endtask

  task automatic check_model();
    logic [NT-1:0] eo, ef;
    for (int i = 0; i < NT; i++) begin
      eo[i] = m_ovf[i];
      ef[i] = m_flag[i];
    end
    chk("model_ovf",  32'(overflow), 32'(eo));
    chk("model_flag", 32'(flag),     32'(ef));
    chk("model_irqn", 32'(irq_n),    32'(~|(ef & irq_en)));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    check_model();
  endtask

  task automatic measure(input int ch, input int exp, input string nm);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    while (!seen && n < 200) begin
      cycle();
      n++;
      if (overflow[ch]) seen = 1;
    end
    chk(nm, 32'(n), 32'(exp));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_flag", 32'(flag), 32'd0);
    chk("rst_ovf",  32'(overflow), 32'd0);
    chk("rst_irqn", 32'(irq_n), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0; cen = 0; zero = 0; run = '0; oneshot = '0;
    clr_flag = '0; irq_en = '1; start_value = '0; presc = '0;

    // Table: ch0 start=1020 presc=0, period 4 ticks; clr collision; start vs tick.
    tbl[0]  = '{1,0,0,0, 0,0,1};
    tbl[1]  = '{1,1,1,0, 0,0,1};
    tbl[2]  = '{1,1,0,0, 0,0,1};
    tbl[3]  = '{1,1,1,0, 0,0,1};
    tbl[4]  = '{1,1,1,0, 0,0,1};
    tbl[5]  = '{1,1,1,0, 1,1,0};
    tbl[6]  = '{1,0,1,0, 0,1,0};
    tbl[7]  = '{1,1,1,0, 0,1,0};
    tbl[8]  = '{1,1,1,1, 0,0,1};
    tbl[9]  = '{1,1,1,0, 0,0,1};
    tbl[10] = '{1,1,1,1, 1,0,1};
    tbl[11] = '{0,1,1,0, 0,0,1};
    tbl[12] = '{0,1,1,0, 0,0,1};
    tbl[13] = '{1,1,1,0, 0,0,1};
    tbl[14] = '{1,1,1,0, 0,0,1};
    tbl[15] = '{1,1,1,0, 0,0,1};
    tbl[16] = '{1,1,1,0, 0,0,1};
    tbl[17] = '{1,1,1,0, 1,1,0};

    start_value[0 +: CW] = 10'd1020;
    start_value[CW +: CW] = 10'd1000;
    do_reset();

    for (int r = 0; r < 18; r++) begin
      run[0] = tbl[r].run0; cen = tbl[r].cen; zero = tbl[r].zero; clr_flag[0] = tbl[r].clr0;
      cycle();
      chk($sformatf("tbl%0d_ovf", r),  32'(overflow[0]), 32'(tbl[r].ovf0));
      chk($sformatf("tbl%0d_flag", r), 32'(flag[0]),     32'(tbl[r].flag0));
      chk($sformatf("tbl%0d_irqn", r), 32'(irq_n),       32'(tbl[r].irqn));
    end
    clr_flag = '0;

    // Prescaler: presc=15 start=1023 -> 16 ticks; presc=3 start=1022 -> 8 ticks.
    run = '0; cen = 1; zero = 1;
    cycle();
    presc[PW +: PW] = 4'd15; start_value[CW +: CW] = 10'd1023;
    run[1] = 1;
    cycle();
    measure(1, 16, "c2_p16_first");
    measure(1, 16, "c2_p16_repeat");
    run[1] = 0;
    cycle();
    presc[PW +: PW] = 4'd3; start_value[CW +: CW] = 10'd1022;
    run[1] = 1;
    cycle();
    measure(1, 8, "c2_p4_first");
    measure(1, 8, "c2_p4_repeat");
    run[1] = 0;

    // One-shot: single overflow, silence, fresh overflow after run toggle.
    oneshot[0] = 1; start_value[0 +: CW] = 10'd1022; presc[0 +: PW] = '0;
    cycle();
    run[0] = 1;
    cycle();
    measure(0, 2, "c3_first");
    cnt = 0;
    repeat (20) begin
      cycle();
      if (overflow[0]) cnt++;
    end
    chk("c3_quiet", 32'(cnt), 32'd0);
    run[0] = 0;
    cycle();
    run[0] = 1;
    cycle();
    measure(0, 2, "c3_restart");

    // irq_en masks/unmasks without a clock edge and leaves flag alone.
    irq_en = '0;
    #1;
    chk("c4_masked", 32'(irq_n), 32'd1);
    irq_en[0] = 1;
    #1;
    chk("c4_unmask", 32'(irq_n), 32'd0);
    chk("c4_flag",   32'(flag[0]), 32'd1);

    // Run low freezes; re-raising reloads start_value and clears pcnt.
    oneshot[0] = 0; start_value[0 +: CW] = 10'd1020; run[0] = 0;
    cycle();
    run[0] = 1;
    cycle();
    cycle();
    cycle();
    run[0] = 0;
    repeat (5) cycle();
    run[0] = 1;
    cycle();
    measure(0, 4, "c5_reload");

    // Randomized phase against the model.
    for (int k = 0; k < 600; k++) begin
      cen = ($urandom % 4) != 0;
      zero = $urandom % 2;
      clr_flag = (($urandom % 16) == 0) ? NT'($urandom) : '0;
      if (($urandom % 10) == 0) irq_en = NT'($urandom);
      for (int i = 0; i < NT; i++) begin
        if (!run[i] && ($urandom % 2)) presc[i*PW +: PW] = PW'($urandom % 4);
        if (($urandom % 20) == 0) run[i] = ~run[i];
        if (($urandom % 8) == 0) start_value[i*CW +: CW] = CW'($urandom_range(1016, 1023));
        if (($urandom % 16) == 0) oneshot[i] = $urandom % 2;
      end
      cycle();
    end

    // Async reset mid-operation with flags set.
    clr_flag = '0; irq_en = '1; oneshot = '0; presc = '0;
    start_value = {10'd1023, 10'd1022};
    run = '0; cen = 1; zero = 1;
    cycle();
    run = '1;
    repeat (3) cycle();
    chk("c6_pre_flag", 32'(flag), 32'h3);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("c6_flag", 32'(flag), 32'd0);
    chk("c6_ovf",  32'(overflow), 32'd0);
    chk("c6_irqn", 32'(irq_n), 32'd1);
    run = '0;
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (8) begin
      cycle();
      if (overflow != '0) cnt++;
    end
    chk("c6_idle", 32'(cnt), 32'd0);
    run[0] = 1;
    cycle();
    measure(0, 2, "c6_restart");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
